// File: rtl/traffic_pkg.sv
// traffic_pkg: definitions shared by the junction phase scheduler and its
// winner-selection logic.
//   - light codes driven per approach onto light_out
//   - scheduler state encoding
//   - width of the per-approach priority / emergency nibbles
package traffic_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_YEL = 2'b01;
  localparam logic [1:0] LIGHT_GRN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } state_e;

endpackage

// File: rtl/phase_select.sv
// phase_select: purely combinational choice of the next approach to receive
// green.
//   pending    - per-approach demand (req or nonzero emergency level)
//   prio       - priority nibble per approach
//   emerg      - emergency level nibble per approach
//   last_grant - approach granted most recently (round-robin anchor)
//   winner     - selected approach index
//   found      - at least one approach is pending
//   is_emerg   - the winner was chosen on emergency level
module phase_select
  import traffic_pkg::*;
#(
  parameter int N_APP = 4,
  parameter int IW    = $clog2(N_APP)
) (
  input  logic [N_APP-1:0]       pending,
  input  logic [NIB_W*N_APP-1:0] prio,
  input  logic [NIB_W*N_APP-1:0] emerg,
  input  logic [IW-1:0]          last_grant,
  output logic [IW-1:0]          winner,
  output logic                   found,
  output logic                   is_emerg
);

  logic [NIB_W-1:0] best_e;
  logic [NIB_W-1:0] best_p;
  logic             rr_found;
  int unsigned      cand;

  // NOTE: every variable assigned here gets a default first so no path
  // leaves it holding its old value, which would infer a latch.
  always_comb begin
    winner   = '0;
    is_emerg = 1'b0;
    best_e   = '0;
    best_p   = '0;
    rr_found = 1'b0;
    cand     = 0;

    // Emergencies: strict '>' scanning upward keeps the lowest index on ties.
    for (int i = 0; i < N_APP; i++) begin
      if (emerg[i*NIB_W +: NIB_W] > best_e) begin
        best_e   = emerg[i*NIB_W +: NIB_W];
        winner   = IW'(i);
        is_emerg = 1'b1;
      end
    end

    // Normal demand: scan in round-robin order from last_grant+1 so the
    // strict '>' hands ties to the approach closest after the last grant.
    if (!is_emerg) begin
      for (int k = 0; k < N_APP; k++) begin
        cand = (int'(last_grant) + 1 + k) % N_APP;
        if (pending[cand] && (!rr_found || prio[cand*NIB_W +: NIB_W] > best_p)) begin
          best_p   = prio[cand*NIB_W +: NIB_W];
          winner   = IW'(cand);
          rr_found = 1'b1;
        end
      end
    end

    found = |pending;
  end

endmodule

// File: rtl/junction_phase_scheduler.sv
// junction_phase_scheduler: sequences the four approaches of one junction
// through GREEN -> YELLOW -> ALLRED, choosing each green by emergency level,
// then priority, then round-robin.
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   req          - vehicle demand per approach
//   prio, emerg  - priority / emergency nibble per approach
//   light_out    - 2-bit light code per approach (registered)
//   grant_idx    - approach holding the phase
//   phase_valid  - high in GREEN and YELLOW
//   emerg_active - current grant was won on emergency level
//   timer        - cycles spent in the current state
module junction_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int N_APP     = 4,
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2,
  parameter int CW        = 8,
  parameter int IW        = $clog2(N_APP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_APP-1:0]       req,
  input  logic [NIB_W*N_APP-1:0] prio,
  input  logic [NIB_W*N_APP-1:0] emerg,
  output logic [2*N_APP-1:0]     light_out,
  output logic [IW-1:0]          grant_idx,
  output logic                   phase_valid,
  output logic                   emerg_active,
  output logic [CW-1:0]          timer
);

  state_e             state_q, state_d;
  logic [CW-1:0]      timer_q, timer_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [2*N_APP-1:0] light_q, light_d;
  logic               pv_q, pv_d;
  logic               ea_q, ea_d;

  logic [N_APP-1:0]   pending;
  logic [IW-1:0]      winner;
  logic               found;
  logic               win_emerg;
  logic               others_pending;
  logic               preempt;
  logic [NIB_W-1:0]   grant_emerg;
  logic [CW-1:0]      timer_inc;

  always_comb begin
    grant_emerg    = emerg[int'(grant_q)*NIB_W +: NIB_W];
    pending        = '0;
    others_pending = 1'b0;
    preempt        = 1'b0;
    for (int j = 0; j < N_APP; j++) begin
      pending[j] = req[j] || (emerg[j*NIB_W +: NIB_W] != '0);
      if (IW'(j) != grant_q) begin
        others_pending = others_pending || pending[j];
        preempt        = preempt || (emerg[j*NIB_W +: NIB_W] > grant_emerg);
      end
    end
  end

  phase_select #(.N_APP(N_APP), .IW(IW)) u_select (
    .pending    (pending),
    .prio       (prio),
    .emerg      (emerg),
    .last_grant (last_q),
    .winner     (winner),
    .found      (found),
    .is_emerg   (win_emerg)
  );

  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ea_d    = ea_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GREEN;
          grant_d = winner;
          last_d  = winner;
          ea_d    = win_emerg;
        end
      end
      S_GREEN: begin
        // Emergency preemption ignores MIN_GREEN; MAX_GREEN overrides the
        // grant's own emergency. All three collapse into one transition.
        if (preempt ||
            (timer_inc >= CW'(MIN_GREEN) && others_pending && grant_emerg == '0) ||
            (timer_inc >= CW'(MAX_GREEN) && others_pending)) begin
          state_d = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer_inc >= CW'(YELLOW)) begin
          state_d = S_ALLRED;
          ea_d    = 1'b0;
        end
      end
      S_ALLRED: begin
        if (timer_inc >= CW'(ALL_RED)) begin
          if (found) begin
            state_d = S_GREEN;
            grant_d = winner;
            last_d  = winner;
            ea_d    = win_emerg;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating at MAX_GREEN also keeps a long IDLE from wrapping.
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q < CW'(MAX_GREEN))
      timer_d = timer_inc;
    else
      timer_d = timer_q;

    // Lights are decoded from the next state so they change on the same
    // edge as the state register.
    light_d = '0;
    for (int i = 0; i < N_APP; i++) begin
      if (IW'(i) == grant_d) begin
        if (state_d == S_GREEN)
          light_d[2*i +: 2] = LIGHT_GRN;
        else if (state_d == S_YELLOW)
          light_d[2*i +: 2] = LIGHT_YEL;
        else
          light_d[2*i +: 2] = LIGHT_RED;
      end
    end
    pv_d = (state_d == S_GREEN) || (state_d == S_YELLOW);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      grant_q <= '0;
      last_q  <= IW'(N_APP - 1);
      light_q <= '0;
      pv_q    <= 1'b0;
      ea_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      light_q <= light_d;
      pv_q    <= pv_d;
      ea_q    <= ea_d;
    end
  end

  assign light_out    = light_q;
  assign grant_idx    = grant_q;
  assign phase_valid  = pv_q;
  assign emerg_active = ea_q;
  assign timer        = timer_q;

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed testbench for junction_phase_scheduler.
module tb_junction_phase_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] prio = '0;
  logic [15:0] emerg = '0;
  logic [7:0]  light_out;
  logic [1:0]  grant_idx;
  logic        phase_valid;
  logic        emerg_active;
  logic [7:0]  timer;

  int vectors = 0;
  int miscompares = 0;

  junction_phase_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .prio         (prio),
    .emerg        (emerg),
    .light_out    (light_out),
    .grant_idx    (grant_idx),
    .phase_valid  (phase_valid),
    .emerg_active (emerg_active),
    .timer        (timer)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; prio = '0; emerg = '0;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({light_out, grant_idx, phase_valid, emerg_active, timer} !== {8'h00, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_state: got light=%b grant=%0d pv=%b ea=%b timer=%0d, want all zero",
               light_out, grant_idx, phase_valid, emerg_active, timer);
      miscompares++;
    end
  endtask

  task automatic test_single_rest();
    do_reset();
    req = 4'b0001;
    tick();
    vectors++;
    if ({light_out, grant_idx, phase_valid} !== {8'b00_00_00_10, 2'd0, 1'b1}) begin
      $display("FAIL single_first_green: got light=%b grant=%0d pv=%b, want 00000010 0 1",
               light_out, grant_idx, phase_valid);
      miscompares++;
    end
    ticks(100);
    vectors++;
    if ({light_out, timer} !== {8'b00_00_00_10, 8'd32}) begin
      $display("FAIL single_rest_saturate: got light=%b timer=%0d, want 00000010 32", light_out, timer);
      miscompares++;
    end
  endtask

  task automatic test_handover();
    logic [7:0] exp;
    do_reset();
    req = 4'b0011;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i <= 8)       exp = 8'h02;
      else if (i <= 12) exp = 8'h01;
      else if (i <= 14) exp = 8'h00;
      else              exp = 8'h08;
      vectors++;
      if (light_out !== exp) begin
        $display("FAIL handover_cycle%0d: got light=%b want %b", i, light_out, exp);
        miscompares++;
      end
    end
    vectors++;
    if (grant_idx !== 2'd1) begin
      $display("FAIL handover_grant: got %0d want 1", grant_idx);
      miscompares++;
    end
    req = 4'b0000;
    ticks(20);
    vectors++;
    if ({light_out, phase_valid} !== {8'h08, 1'b1}) begin
      $display("FAIL handover_rest: got light=%b pv=%b want 00001000 1", light_out, phase_valid);
      miscompares++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    req = 4'b1111;
    prio = 16'h0080;
    tick();
    vectors++;
    if ({grant_idx, light_out} !== {2'd1, 8'h08}) begin
      $display("FAIL prio_first: got grant=%0d light=%b want 1 00001000", grant_idx, light_out);
      miscompares++;
    end
    ticks(14);
    vectors++;
    if ({grant_idx, light_out} !== {2'd1, 8'h08}) begin
      $display("FAIL prio_repeat: got grant=%0d light=%b want 1 00001000", grant_idx, light_out);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [5];
    logic [7:0] exp;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k != 0) ticks(14);
      exp = 8'b10 << (2 * seq[k]);
      vectors++;
      if ({grant_idx, light_out} !== {seq[k], exp}) begin
        $display("FAIL rr_grant%0d: got grant=%0d light=%b want %0d %b", k, grant_idx, light_out, seq[k], exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_emergency();
    int bad;
    do_reset();
    req = 4'b0001;
    tick();
    ticks(2);
    vectors++;
    if ({light_out, timer} !== {8'h02, 8'd2}) begin
      $display("FAIL emerg_pre: got light=%b timer=%0d want 00000010 2", light_out, timer);
      miscompares++;
    end
    emerg = 16'h0200;
    tick();
    vectors++;
    if ({light_out, phase_valid, emerg_active} !== {8'h01, 1'b1, 1'b0}) begin
      $display("FAIL emerg_preempt_yellow: got light=%b pv=%b ea=%b want 00000001 1 0",
               light_out, phase_valid, emerg_active);
      miscompares++;
    end
    ticks(6);
    vectors++;
    if ({light_out, grant_idx, emerg_active} !== {8'h20, 2'd2, 1'b1}) begin
      $display("FAIL emerg_r_green: got light=%b grant=%0d ea=%b want 00100000 2 1",
               light_out, grant_idx, emerg_active);
      miscompares++;
    end
    req = 4'b0000;
    emerg = 16'h1200;
    bad = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (light_out !== 8'h20) bad++;
    end
    vectors++;
    if (bad != 0 || timer !== 8'd31) begin
      $display("FAIL emerg_hold: got %0d non-green cycles timer=%0d want 0 31", bad, timer);
      miscompares++;
    end
    tick();
    vectors++;
    if ({light_out, emerg_active} !== {8'h10, 1'b1}) begin
      $display("FAIL emerg_maxgreen_yellow: got light=%b ea=%b want 00010000 1", light_out, emerg_active);
      miscompares++;
    end
    ticks(4);
    vectors++;
    if ({light_out, phase_valid, emerg_active} !== {8'h00, 1'b0, 1'b0}) begin
      $display("FAIL emerg_allred_clear: got light=%b pv=%b ea=%b want 00000000 0 0",
               light_out, phase_valid, emerg_active);
      miscompares++;
    end
  endtask

  task automatic test_reset_in_yellow();
    do_reset();
    req = 4'b0011;
    ticks(10);
    vectors++;
    if (light_out !== 8'h01) begin
      $display("FAIL ry_in_yellow: got light=%b want 00000001", light_out);
      miscompares++;
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({light_out, grant_idx, phase_valid, emerg_active, timer} !== {8'h00, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL ry_reset: got light=%b grant=%0d pv=%b ea=%b timer=%0d want all zero",
               light_out, grant_idx, phase_valid, emerg_active, timer);
      miscompares++;
    end
    rst = 1'b0;
    req = 4'b0100;
    tick();
    vectors++;
    if ({light_out, grant_idx, phase_valid} !== {8'h20, 2'd2, 1'b1}) begin
      $display("FAIL ry_r_green: got light=%b grant=%0d pv=%b want 00100000 2 1",
               light_out, grant_idx, phase_valid);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single_rest();
    test_handover();
    test_priority();
    test_round_robin();
    test_emergency();
    test_reset_in_yellow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Per-junction phase scheduler that sequences the four approaches (F, L, R, B) of one traffic junction through green, yellow and all-red intervals. It picks the next green from per-approach demand, 4-bit priority and 4-bit emergency level. It sits beside each signal instance in the multi-junction traffic system and owns the light state driven onto the approach outputs.

## Interface
- `N_APP`, 4, number of approaches; index 0=F, 1=L, 2=R, 3=B.
- `MIN_GREEN`, 8, minimum green cycles before a non-emergency handover.
- `MAX_GREEN`, 32, green cycles after which a handover is forced if another approach is pending.
- `YELLOW`, 4, yellow interval in cycles.
- `ALL_RED`, 2, all-red clearance in cycles.
- `CW`, 8, timer width; must hold MAX_GREEN.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_APP  vehicle demand per approach.
- `prio`  in  4*N_APP  priority per approach, nibble i = approach i; 0 is lowest but still eligible.
- `emerg`  in  4*N_APP  emergency level per approach; nonzero = emergency.
- `light_out`  out  2*N_APP  per approach: 00 red, 01 yellow, 10 green; 11 never driven.
- `grant_idx`  out  2  approach currently holding the phase.
- `phase_valid`  out  1  high in GREEN and YELLOW.
- `emerg_active`  out  1  current grant was won by emergency.
- `timer`  out  CW  cycles elapsed in the current state.

## Operation
- Pending(i) = req[i] or emerg[i] != 0.
- The winner is selected in this order:
  - If any emergency is present: highest emergency level wins; ties go to the lowest index.
  - Otherwise, among pending approaches: highest prio wins; ties are broken round-robin starting at last_grant+1 mod N_APP.
- FSM states: IDLE, GREEN, YELLOW, ALLRED.
- IDLE:
  - All lights red, phase_valid=0.
  - If any approach is pending, latch the winner and go to GREEN next cycle. Otherwise stay in IDLE.
- GREEN:
  - The granted approach is 10; all others are 00.
  - Go to YELLOW when any of these holds:
    - (a) Another approach j != grant has emerg[j] > emerg[grant]. This preemption ignores MIN_GREEN.
    - (b) timer+1 >= MIN_GREEN, another approach is pending, and no emergency is present on the grant.
    - (c) timer+1 >= MAX_GREEN and another approach is pending, regardless of the grant's own emergency.
  - If no other approach is pending, rest in GREEN. The timer saturates at MAX_GREEN.
  - Dropping the grant's own req does not end green.
- YELLOW:
  - The granted approach is 01.
  - After YELLOW cycles, go to ALLRED.
  - The phase is never aborted or extended by new requests.
- ALLRED:
  - All lights 00, phase_valid=0.
  - After ALL_RED cycles, evaluate the winner on that cycle's inputs. If one exists, go to GREEN with it; otherwise go to IDLE.
  - The previous grant may win again.
- last_grant updates on every entry to GREEN.
- emerg_active latches (emerg[winner] != 0) on GREEN entry and clears on leaving YELLOW.
- The timer resets to 0 on every state change and increments each cycle in a state.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Reset values: state IDLE, light_out all 00, grant_idx 0, phase_valid 0, emerg_active 0, timer 0, last_grant N_APP-1 (so round-robin starts at 0).
- Latencies:
  - req asserted in IDLE gives green on light_out 1 cycle later.
  - Green lasts at least MIN_GREEN cycles unless preempted by an emergency.
  - Yellow lasts exactly YELLOW cycles; all-red lasts exactly ALL_RED cycles.
- An emergency preemption asserted in cycle t during GREEN gives yellow at t+1.
- Inputs may change every cycle; only the sampling-cycle values matter, with no internal request memory.
- Simultaneous preemption and MAX_GREEN in the same cycle resolve to a single YELLOW transition.
- Reset asserted mid-phase returns to IDLE all-red on the next edge, with no yellow.

## Structure
- The shared package `traffic_pkg` holds:
  - light codes LIGHT_RED/LIGHT_YEL/LIGHT_GRN;
  - the state enum {IDLE, GREEN, YELLOW, ALLRED};
  - the emergency and priority nibble width.
- One combinational sub-module, `phase_select`: takes pending, prio, emerg and last_grant; returns winner index, found and is_emerg.
- The scheduler top holds the FSM, timer, last_grant and output registers.

## Test plan
- Reset, then req=0001 with all prio 0: light_out=00_00_00_10 one cycle later, phase_valid=1, grant_idx=0. Holding it for 100 cycles keeps green and saturates the timer at 32.
- req=0011, prio all 0: F green for 8 cycles, then 4 yellow, 2 all-red, then L green. Dropping req afterwards leaves L resting in green.
- req=1111 with prio L=8, others 0: L wins every time it is pending against others. With equal prio, grants rotate 0→1→2→3→0.
- F green at timer 2, emerg nibble R=2: yellow next cycle, then after all-red R green with emerg_active=1. A later emerg B=1 does not preempt; R keeps green until MAX_GREEN (32 cycles) with B pending.
- Reset asserted during YELLOW: all outputs return to reset values on the next edge. A fresh req=0100 then gives R green 1 cycle after reset release.
